lx32_dmem_responder: RTL
========================

Name: lx32_dmem_responder

Overview:
- Responder end of the LX32 core's data memory interface: decodes mem_addr/mem_we/mem_wdata and returns mem_rdata in the same cycle, as the single-cycle datapath requires.
- Contains a word-addressed data RAM plus an MMIO page: console TX FIFO with valid/ready drain, status register, free-running cycle counter, scratch register.
- Sits beside the core in the system top; the console port connects to a UART or testbench sink.

Parameters:
- RAM_WORDS, 1024, data RAM depth in 32-bit words; power of two; RAM occupies byte addresses 0 .. RAM_WORDS*4-1.
- FIFO_DEPTH, 8, console TX FIFO entries; power of two, at least 2.
- MMIO_BASE, 32'h8000_0000, base of the 16-byte MMIO page; must not overlap RAM.

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- mem_addr  in  32  byte address from the core, valid every cycle
- mem_wdata  in  32  store data
- mem_we  in  1  store strobe, sampled at posedge
- mem_rdata  out  32  combinational read data for mem_addr
- console_data  out  8  FIFO head byte
- console_valid  out  1  FIFO non-empty
- console_ready  in  1  sink accepts the head byte this cycle
- fault  out  1  sticky access fault flag

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. Reset is fixed for this block.
- Reads have no side effects. The core presents an address every cycle with no read strobe.
- mem_rdata is purely combinational from current state. A write in cycle N is visible on reads from cycle N+1. A same-cycle read returns the old value.
- RAM region:
  - Word index is mem_addr[log2(RAM_WORDS)+1:2].
  - Write on posedge when mem_we=1 and addr[1:0]=0. Full 32-bit write, no byte enables.
  - Misaligned write: ignored and sets fault. Misaligned read returns the word at the aligned address.
  - RAM contents are not reset.
- MMIO region, offsets from MMIO_BASE:
  - 0x0 TX: a write pushes wdata[7:0]; reads return 0.
  - 0x4 STATUS, read: [0] empty, [1] full, [2] overflow sticky, [3] fault, [15:8] FIFO count, others 0. Write: 1 in bit 2 clears overflow, 1 in bit 3 clears fault.
  - 0x8 CYCLE: 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF to 0. A write loads wdata (load takes priority over increment), so the next cycle reads wdata and the one after reads wdata+1.
  - 0xC SCRATCH: plain read/write register.
- Any other address: reads return 0. Writes are ignored and set fault.
- Fault-clear vs new fault in the same cycle: the set wins.
- Console FIFO:
  - Circular buffer with pointer wrap at FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - console_valid = count != 0. console_data = head entry, held stable while valid && !ready.
  - Pop on posedge when valid && ready.
  - Push on a TX write when not full. Push when full with no pop: byte dropped, overflow set, count unchanged.
  - Push while full with a same-cycle pop: accepted, count stays FIFO_DEPTH.
  - Push and pop when neither empty nor full: count unchanged.
  - No bypass: a push into an empty FIFO raises console_valid the next cycle.
- Reset values, applied immediately on rst_n low, including mid-transfer:
  - count=0, pointers=0, console_valid=0.
  - overflow=0, fault=0, CYCLE=0, SCRATCH=0.
  - mem_rdata reflects the reset state. console_data is don't-care while invalid.
- Arithmetic: all address comparisons are full 32-bit unsigned. CYCLE and pointers are modulo their widths.

Test Plan:
- Write 0xDEADBEEF to addr 0x10; in the same cycle rdata at 0x10 shows the old value; next cycle reads 0xDEADBEEF. Write to 0x12 -> RAM unchanged, fault=1, STATUS[3]=1. Write 0x8 to STATUS -> fault=0.
- Hold console_ready=0 and write TX 'A'..'I' (9 bytes, FIFO_DEPTH=8) -> count=8, full=1, overflow=1. Release ready -> 'A'..'H' drain in order, one per cycle, then valid=0.
- FIFO full, same cycle TX write 'Z' and ready=1 -> 'A' popped, count stays 8, overflow stays 0, 'Z' is the last byte out.
- Write CYCLE=0xFFFF_FFFE -> reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000 on consecutive cycles.
- Write SCRATCH=0x1234 and push 3 TX bytes, then pulse rst_n low mid-drain -> console_valid=0 immediately; SCRATCH=0, CYCLE=0, STATUS=0x0000_0001.
- Write to MMIO_BASE+0x10 -> fault=1 and rdata=0. Reading RAM or STATUS repeatedly changes no state.

Source files
------------

// File: rtl/lx32_dmem_responder.sv
// lx32_dmem_responder
// Responder side of the LX32 data memory interface. The single-cycle core
// presents an address every cycle and expects read data in the same cycle.
// The block holds a word-addressed data RAM and a 16-byte MMIO page with
// four registers:
//   - console TX FIFO push port
//   - status register
//   - free-running cycle counter
//   - scratch register
// Stores take effect on the rising clock edge. Reads are side-effect free.

module lx32_dmem_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    output logic [31:0] mem_rdata,
    output logic [7:0]  console_data,
    output logic        console_valid,
    input  logic        console_ready,
    output logic        fault
);

    // Address and pointer geometry
    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [31:0]   RAM_BYTES = 32'(RAM_WORDS) << 2;
    localparam logic [31:0]   ADDR_TX   = MMIO_BASE + 32'h0000_0000;
    localparam logic [31:0]   ADDR_STAT = MMIO_BASE + 32'h0000_0004;
    localparam logic [31:0]   ADDR_CYC  = MMIO_BASE + 32'h0000_0008;
    localparam logic [31:0]   ADDR_SCR  = MMIO_BASE + 32'h0000_000C;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   r_ram [RAM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic          r_overflow;
    logic          r_fault;
    logic [31:0]   r_cycle;
    logic [31:0]   r_scratch;

    // ------------------------------------------------------------------
    // Address decode: every comparison is a full 32-bit unsigned compare.
    // MMIO registers decode only at their exact word addresses; any other
    // byte inside or outside the page counts as an unmapped address.
    // ------------------------------------------------------------------
    logic          w_in_ram;
    logic          w_aligned;
    logic          w_hit_tx;
    logic          w_hit_stat;
    logic          w_hit_cyc;
    logic          w_hit_scr;
    logic          w_hit_mmio;
    logic [AW-1:0] w_ram_idx;

    assign w_in_ram   = (mem_addr < RAM_BYTES);
    assign w_aligned  = (mem_addr[1:0] == 2'b00);
    assign w_hit_tx   = (mem_addr == ADDR_TX);
    assign w_hit_stat = (mem_addr == ADDR_STAT);
    assign w_hit_cyc  = (mem_addr == ADDR_CYC);
    assign w_hit_scr  = (mem_addr == ADDR_SCR);
    assign w_hit_mmio = w_hit_tx | w_hit_stat | w_hit_cyc | w_hit_scr;
    // Misaligned reads fall back to the containing word.
    assign w_ram_idx  = mem_addr[AW+1:2];

    // Store qualification
    logic w_ram_wr;
    logic w_tx_wr;
    logic w_stat_wr;
    logic w_cyc_wr;
    logic w_scr_wr;
    logic w_bad_wr;

    assign w_ram_wr  = mem_we & w_in_ram & w_aligned;
    assign w_tx_wr   = mem_we & w_hit_tx;
    assign w_stat_wr = mem_we & w_hit_stat;
    assign w_cyc_wr  = mem_we & w_hit_cyc;
    assign w_scr_wr  = mem_we & w_hit_scr;
    // Misaligned RAM stores and stores to unmapped space are dropped and
    // flagged.
    assign w_bad_wr  = mem_we & ((w_in_ram & ~w_aligned) | (~w_in_ram & ~w_hit_mmio));

    // ------------------------------------------------------------------
    // Console FIFO control
    // ------------------------------------------------------------------
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_nxt;

    assign w_empty = (r_count == CW'(0));
    assign w_full  = (r_count == DEPTH_C);
    assign w_pop   = r_valid & console_ready;
    // A same-cycle pop frees the slot, so a push into a full FIFO is
    // still accepted in that case.
    assign w_push  = w_tx_wr & (~w_full | w_pop);
    assign w_drop  = w_tx_wr & w_full & ~w_pop;

    // Next occupancy from the push/pop pair
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------
    // Read path: purely combinational from current state.
    // ------------------------------------------------------------------
    logic [31:0] w_status;
    logic [31:0] w_rdata;

    assign w_status = {16'h0000, 8'(r_count), 4'h0, r_fault, r_overflow, w_full, w_empty};

    // Read data mux; TX and unmapped addresses read as zero
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (w_in_ram) begin
            w_rdata = r_ram[w_ram_idx];
        end else if (w_hit_stat) begin
            w_rdata = w_status;
        end else if (w_hit_cyc) begin
            w_rdata = r_cycle;
        end else if (w_hit_scr) begin
            w_rdata = r_scratch;
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Data RAM: full-word aligned stores, contents deliberately not reset
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_ram[w_ram_idx] <= mem_wdata;
        end
    end

    // FIFO storage: accepted byte lands at the write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo[i] <= 8'h00;
            end
        end else if (w_push) begin
            r_fifo[r_wr_ptr] <= mem_wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and the registered valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= PW'(0);
            r_rd_ptr <= PW'(0);
            r_count  <= CW'(0);
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != CW'(0));
        end
    end

    // Sticky overflow: set by a dropped push, cleared by STATUS bit 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_stat_wr && mem_wdata[2]) begin
            r_overflow <= 1'b0;
        end
    end

    // Sticky fault: a new fault wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_bad_wr) begin
            r_fault <= 1'b1;
        end else if (w_stat_wr && mem_wdata[3]) begin
            r_fault <= 1'b0;
        end
    end

    // Cycle counter: a load takes priority over the increment, wraps modulo 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle <= 32'h0000_0000;
        end else if (w_cyc_wr) begin
            r_cycle <= mem_wdata;
        end else begin
            r_cycle <= r_cycle + 32'h0000_0001;
        end
    end

    // Scratch register: plain read/write storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scratch <= 32'h0000_0000;
        end else if (w_scr_wr) begin
            r_scratch <= mem_wdata;
        end
    end

    // Output mapping
    assign mem_rdata     = w_rdata;
    assign console_data  = r_fifo[r_rd_ptr];
    assign console_valid = r_valid;
    assign fault         = r_fault;

endmodule
